// File: rtl/led_out_pkg.sv
// Shared types and widths for the LED output stage (led_pwm_driver and its tick generator).
package led_out_pkg;

  localparam int unsigned LED_W = 8;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    SHOW = 1'b0,
    PEND = 1'b1
  } led_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus free-running PWM counter; flags each PWM tick and each period wrap.
module pwm_tick_gen #(
  parameter int unsigned PWM_BITS = 3,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                wrap
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    tick      = (presc_q == PRE_W'(PRESCALE - 1));
    wrap      = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});
    presc_d   = tick ? '0 : presc_q + PRE_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: PWM dimming with period-aligned, minimum-hold pattern updates.
// Blink blanking is built only when LED_BLINK_EN is defined.
module led_pwm_driver
  import led_out_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 3,
  parameter int unsigned PRESCALE      = 1,
  parameter int unsigned MIN_HOLD      = 2,
  parameter int unsigned BLINK_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED_W-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink,
  output logic [LED_W-1:0]    led,
  output logic                pattern_changed,
  output logic [CNT_W-1:0]    change_count,
  output logic                busy
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;
  logic                unused_tick;

  pwm_tick_gen #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .tick    (unused_tick),
    .wrap    (wrap)
  );

  led_state_e          state_q, state_d;
  logic [LED_W-1:0]    applied_q, applied_d;
  logic [LED_W-1:0]    pending_q, pending_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                pattern_changed_q, pattern_changed_d;
  logic [CNT_W-1:0]    change_count_q, change_count_d;
  logic                busy_q, busy_d;
  logic                apply;
  logic                lit;
  logic                show_on;

`ifdef LED_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_on_q, blink_on_d;

  // Blink phase advances on period wraps only; dropping blink snaps back to the on phase.
  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    blink_on_d = blink_on_q;
    if (!blink) begin
      blk_cnt_d  = '0;
      blink_on_d = 1'b1;
    end else if (wrap) begin
      if (blk_cnt_q == BLK_W'(BLINK_PERIODS - 1)) begin
        blk_cnt_d  = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q  <= '0;
      blink_on_q <= 1'b1;
    end else begin
      blk_cnt_q  <= blk_cnt_d;
      blink_on_q <= blink_on_d;
    end
  end

  assign show_on = blink_on_q;
`else
  localparam int unsigned UNUSED_BLINK_PERIODS = BLINK_PERIODS;
  logic unused_blink;
  assign unused_blink = blink;
  assign show_on      = 1'b1;
`endif

  // Pattern update FSM; a pending change lands only on a wrap once the hold time is met.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    applied_d = applied_q;
    apply     = 1'b0;
    case (state_q)
      SHOW: begin
        if (pattern_in != applied_q) begin
          pending_d = pattern_in;
          state_d   = PEND;
        end
      end
      PEND: begin
        pending_d = pattern_in;
        if (pattern_in == applied_q) begin
          state_d = SHOW;
        end else if (wrap && (hold_q >= HOLD_W'(MIN_HOLD))) begin
          apply     = 1'b1;
          applied_d = pending_d;
          state_d   = SHOW;
        end
      end
      default: state_d = SHOW;
    endcase

    hold_d = hold_q;
    if (apply) begin
      hold_d = '0;
    end else if (wrap && (hold_q < HOLD_W'(MIN_HOLD))) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    duty_d            = wrap ? brightness : duty_q;
    lit               = (duty_q == {PWM_BITS{1'b1}}) || (pwm_cnt < duty_q);
    led_d             = (lit && show_on) ? applied_q : '0;
    pattern_changed_d = apply;
    change_count_d    = apply ? change_count_q + CNT_W'(1) : change_count_q;
    busy_d            = (state_d == PEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= SHOW;
      applied_q         <= '0;
      pending_q         <= '0;
      hold_q            <= '0;
      duty_q            <= '0;
      led_q             <= '0;
      pattern_changed_q <= 1'b0;
      change_count_q    <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      applied_q         <= applied_d;
      pending_q         <= pending_d;
      hold_q            <= hold_d;
      duty_q            <= duty_d;
      led_q             <= led_d;
      pattern_changed_q <= pattern_changed_d;
      change_count_q    <= change_count_d;
      busy_q            <= busy_d;
    end
  end

  assign led             = led_q;
  assign pattern_changed = pattern_changed_q;
  assign change_count    = change_count_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: scheduled expectations checked on the falling edge.
// Blink expectations follow LED_BLINK_EN so the same bench serves both builds.
module tb_led_pwm_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pattern_in = 8'hA5;
  logic [2:0]  brightness = 3'd7;
  logic        blink = 1'b0;
  logic [7:0]  led;
  logic        pattern_changed;
  logic [15:0] change_count;
  logic        busy;

  int cyc = 0;
  int rel = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    int          due;
    logic [7:0]  led;
    logic        pc;
    logic [15:0] cnt;
    logic        busy;
    logic [3:0]  mask;
  } exp_t;

  typedef struct {
    logic [2:0] bright;
    logic [2:0] glitch;
    logic [7:0] lit;
  } pwm_vec_t;

  exp_t     sb[$];
  pwm_vec_t vecs[6];

  led_pwm_driver #(
    .PWM_BITS      (3),
    .PRESCALE      (1),
    .MIN_HOLD      (2),
    .BLINK_PERIODS (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pattern_in      (pattern_in),
    .brightness      (brightness),
    .blink           (blink),
    .led             (led),
    .pattern_changed (pattern_changed),
    .change_count    (change_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic exp_rng(input string nm, input int c0, input int c1, input logic [7:0] l,
                         input logic p, input logic [15:0] n, input logic b, input logic [3:0] m);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.name = nm;
      e.due  = rel + c;
      e.led  = l;
      e.pc   = p;
      e.cnt  = n;
      e.busy = b;
      e.mask = m;
      sb.push_back(e);
    end
  endtask

  task automatic check(input exp_t e);
    logic ok;
    ok = (e.due == cyc);
    if (e.mask[0] && (led !== e.led)) ok = 1'b0;
    if (e.mask[1] && (pattern_changed !== e.pc)) ok = 1'b0;
    if (e.mask[2] && (change_count !== e.cnt)) ok = 1'b0;
    if (e.mask[3] && (busy !== e.busy)) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s c=%0d: got led=%h pc=%b cnt=%h busy=%b, required led=%h pc=%b cnt=%h busy=%b (due %0d)",
               e.name, cyc - rel, led, pattern_changed, change_count, busy,
               e.led, e.pc, e.cnt, e.busy, e.due - rel);
    end
  endtask

  task automatic scan();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int c);
    while ((cyc - rel) < c) @(negedge clk);
    if ((cyc - rel) != c) begin
      total++;
      bad++;
      $display("FAIL run_to: at c=%0d, required c=%0d", cyc - rel, c);
    end
  endtask

  initial begin
    vecs[0] = '{3'd3, 3'd7, 8'h07};
    vecs[1] = '{3'd0, 3'd7, 8'h00};
    vecs[2] = '{3'd7, 3'd0, 8'hFF};
    vecs[3] = '{3'd1, 3'd5, 8'h01};
    vecs[4] = '{3'd6, 3'd2, 8'h3F};
    vecs[5] = '{3'd4, 3'd0, 8'h0F};

    fork
      forever begin
        @(negedge clk);
        scan();
      end
    join_none

    // Reset held for three edges.
    exp_rng("reset", 1, 3, 8'h00, 1'b0, 16'h0000, 1'b0, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;

    // First pattern, then 0F, then 01 one period after 0F lands, then FF.
    exp_rng("t1_pend",     1, 23, 8'h00, 1'b0, 16'd0, 1'b1, 4'hF);
    exp_rng("t1_apply",   24, 24, 8'h00, 1'b1, 16'd1, 1'b0, 4'hF);
    exp_rng("t1_show",    25, 47, 8'hA5, 1'b0, 16'd1, 1'b1, 4'hF);
    exp_rng("t2_apply0f", 48, 48, 8'hA5, 1'b1, 16'd2, 1'b0, 4'hF);
    exp_rng("t2_show0f",  49, 56, 8'h0F, 1'b0, 16'd2, 1'b0, 4'hF);
    exp_rng("t2_pend01",  57, 71, 8'h0F, 1'b0, 16'd2, 1'b1, 4'hF);
    exp_rng("t2_apply01", 72, 72, 8'h0F, 1'b1, 16'd3, 1'b0, 4'hF);
    exp_rng("t2_pendff",  73, 95, 8'h01, 1'b0, 16'd3, 1'b1, 4'hF);
    exp_rng("t2_applyff", 96, 96, 8'h01, 1'b1, 16'd4, 1'b0, 4'hF);
    exp_rng("t2_showff",  97, 104, 8'hFF, 1'b0, 16'd4, 1'b0, 4'hF);
    run_to(24); pattern_in = 8'h0F;
    run_to(56); pattern_in = 8'h01;
    run_to(72); pattern_in = 8'hFF;

    // Duty table: brightness set before a wrap, a mid-period change must be ignored.
    for (int k = 0; k < 6; k++) begin
      int p0;
      p0 = 104 + 8 * k;
      run_to(p0 - 1);
      brightness = vecs[k].bright;
      for (int p = 0; p < 8; p++) begin
        logic [7:0] m;
        m = vecs[k].lit;
        exp_rng($sformatf("pwm%0d_b%0d_ph%0d", k, vecs[k].bright, p), p0 + 1 + p, p0 + 1 + p,
                m[p] ? 8'hFF : 8'h00, 1'b0, 16'd4, 1'b0, 4'hF);
      end
      run_to(p0 + 3);
      brightness = vecs[k].glitch;
    end
    run_to(151);
    brightness = 3'd7;

    // Latest-wins in PEND, cancel by returning to applied, then reset mid-PEND.
    exp_rng("t4_pre",    153, 161, 8'hFF, 1'b0, 16'd4, 1'b0, 4'hF);
    exp_rng("t4_pend",   162, 167, 8'hFF, 1'b0, 16'd4, 1'b1, 4'hF);
    exp_rng("t4_apply",  168, 168, 8'hFF, 1'b1, 16'd5, 1'b0, 4'hF);
    exp_rng("t4_show",   169, 170, 8'h33, 1'b0, 16'd5, 1'b0, 4'hF);
    exp_rng("t5_pend",   171, 173, 8'h33, 1'b0, 16'd5, 1'b1, 4'hF);
    exp_rng("t5_cancel", 174, 200, 8'h33, 1'b0, 16'd5, 1'b0, 4'hF);
    exp_rng("t7_pend",   201, 203, 8'h33, 1'b0, 16'd5, 1'b1, 4'hF);
    exp_rng("t7_reset",  204, 205, 8'h00, 1'b0, 16'd0, 1'b0, 4'hF);
    run_to(161); pattern_in = 8'h11;
    run_to(163); pattern_in = 8'h22;
    run_to(165); pattern_in = 8'h33;
    run_to(170); pattern_in = 8'h44;
    run_to(173); pattern_in = 8'h33;
    run_to(200); pattern_in = 8'h77;
    run_to(203); rst = 1'b1; pattern_in = 8'h00;
    run_to(205); rst = 1'b0;
    rel = cyc;

    exp_rng("t7_idle", 1, 39, 8'h00, 1'b0, 16'd0, 1'b0, 4'hF);
    run_to(40);
    force dut.change_count_q = 16'hFFFF;
    run_to(41);
    release dut.change_count_q;

    // Counter wrap from FFFF, then blink blanking on the newly applied pattern.
    exp_rng("t6_preload", 42, 42, 8'h00, 1'b0, 16'hFFFF, 1'b0, 4'hF);
    exp_rng("t6_pend",    43, 47, 8'h00, 1'b0, 16'hFFFF, 1'b1, 4'hF);
    exp_rng("t6_wrap",    48, 48, 8'h00, 1'b1, 16'h0000, 1'b0, 4'hF);
    exp_rng("t6_show",    49, 80, 8'h5A, 1'b0, 16'h0000, 1'b0, 4'hF);
`ifdef LED_BLINK_EN
    exp_rng("blink_off1",  81, 112, 8'h00, 1'b0, 16'h0000, 1'b0, 4'hF);
    exp_rng("blink_on1",  113, 144, 8'h5A, 1'b0, 16'h0000, 1'b0, 4'hF);
    exp_rng("blink_off2", 145, 176, 8'h00, 1'b0, 16'h0000, 1'b0, 4'hF);
    exp_rng("blink_stop", 177, 224, 8'h5A, 1'b0, 16'h0000, 1'b0, 4'hF);
`else
    exp_rng("no_blank",    81, 224, 8'h5A, 1'b0, 16'h0000, 1'b0, 4'hF);
`endif
    run_to(42);  pattern_in = 8'h5A;
    run_to(55);  blink = 1'b1;
    run_to(190); blink = 1'b0;
    run_to(226);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
